// File: rtl/round_robin_encoder_32.sv
// round_robin_encoder_32: 32-channel round-robin arbiter whose outputs feed a
// downstream 5:32 decoder (Grant_Valid_Out = enable, Grant_Index_Out = code).
// A grant is held until Release_In, until Enable_In drops, or until it has
// lasted HOLD_LIMIT cycles. A forced release pulses Timeout_Out for one cycle.
module round_robin_encoder_32 #(
  parameter int unsigned HOLD_LIMIT = 16  // legal range 1..255
) (
  input  logic        Clock_In,
  input  logic        Reset_n_In,
  input  logic        Enable_In,
  input  logic [31:0] Request_In,
  input  logic        Release_In,
  output logic        Grant_Valid_Out,
  output logic [4:0]  Grant_Index_Out,
  output logic        Timeout_Out
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_LIMIT - 1);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [7:0]  hold_q, hold_d;
  logic        valid_q, valid_d;
  logic [4:0]  index_q, index_d;
  logic        timeout_q, timeout_d;

  logic        req_found;
  logic [4:0]  req_sel;
  logic [4:0]  probe;

  // Find the first requesting channel at or above the pointer, wrapping 31->0.
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    probe     = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      probe = ptr_q + i[4:0];
      if (!req_found && Request_In[probe]) begin
        req_found = 1'b1;
        req_sel   = probe;
      end
    end
  end

  // Next-state logic for the grant FSM, pointer, hold counter and outputs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    index_d   = index_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Release_In is ignored here; index keeps its last value.
        valid_d = 1'b0;
        if (Enable_In && req_found) begin
          state_d = GRANTED;
          index_d = req_sel;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANTED: begin
        // Priority: explicit release, then forced release, then enable drop.
        if (Release_In) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ptr_d   = index_q + 5'd1;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          ptr_d     = index_q + 5'd1;
          timeout_d = 1'b1;
        end else if (!Enable_In) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      index_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      index_q   <= index_d;
      timeout_q <= timeout_d;
    end
  end

  assign Grant_Valid_Out = valid_q;
  assign Grant_Index_Out = index_q;
  assign Timeout_Out     = timeout_q;

endmodule

// File: tb/tb_round_robin_encoder_32.sv
// Testbench for round_robin_encoder_32: directed scenarios followed by random
// traffic, every cycle compared against a behavioural arbiter model.
module tb_round_robin_encoder_32;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] req;
  logic        rel;
  logic        valid;
  logic [4:0]  index;
  logic        tout;

  int n_total;
  int n_pass;

  // Behavioural model: who holds the grant, for how many cycles, and where
  // the next search starts.
  bit m_busy;
  int m_idx;
  int m_ptr;
  int m_age;
  bit m_to;

  round_robin_encoder_32 #(.HOLD_LIMIT(HOLD)) dut (
    .Clock_In        (clk),
    .Reset_n_In      (rst_n),
    .Enable_In       (en),
    .Request_In      (req),
    .Release_In      (rel),
    .Grant_Valid_Out (valid),
    .Grant_Index_Out (index),
    .Timeout_Out     (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_idx  = 0;
    m_ptr  = 0;
    m_age  = 0;
    m_to   = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_step();
    bit hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_to = 1'b0;
    if (!m_busy) begin
      if (en && req != 0) begin
        hit = 1'b0;
        for (int k = 0; k < 32; k++) begin
          if (!hit && req[(m_ptr + k) % 32]) begin
            hit   = 1'b1;
            m_idx = (m_ptr + k) % 32;
          end
        end
        m_busy = 1'b1;
        m_age  = 1;
      end
    end else if (rel) begin
      m_busy = 1'b0;
      m_ptr  = (m_idx + 1) % 32;
    end else if (m_age == HOLD) begin
      m_busy = 1'b0;
      m_ptr  = (m_idx + 1) % 32;
      m_to   = 1'b1;
    end else if (!en) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, m_busy});
    check({tag, ".index"}, {27'd0, index}, m_idx);
    check({tag, ".timeout"}, {31'd0, tout}, {31'd0, m_to});
  endtask

  // One clock: edge, model update, then sample 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  int cnt;

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    rel   = 1'b0;
    model_reset();

    // Reset state
    #3;
    check("reset.valid", {31'd0, valid}, 32'd0);
    check("reset.index", {27'd0, index}, 32'd0);
    check("reset.timeout", {31'd0, tout}, 32'd0);
    cycle("reset_hold");
    rst_n = 1'b1;

    // Basic grant from channel 0, release, next grant is channel 2
    en  = 1'b1;
    req = 32'h0000_0005;
    cycle("basic_g0");
    check("basic.first_idx", {27'd0, index}, 32'd0);
    check("basic.first_valid", {31'd0, valid}, 32'd1);
    rel = 1'b1;
    cycle("basic_rel");
    check("basic.rel_valid", {31'd0, valid}, 32'd0);
    rel = 1'b0;
    cycle("basic_g2");
    check("basic.second_idx", {27'd0, index}, 32'd2);
    rel = 1'b1;
    cycle("basic_rel2");
    rel = 1'b0;

    // Wrap: grant on 30 -> pointer 31 -> grant 31 -> then 0
    req = 32'h4000_0000;
    cycle("wrap_g30");
    check("wrap.idx30", {27'd0, index}, 32'd30);
    rel = 1'b1;
    req = 32'h8000_0001;
    cycle("wrap_rel30");
    rel = 1'b0;
    cycle("wrap_g31");
    check("wrap.idx31", {27'd0, index}, 32'd31);
    rel = 1'b1;
    cycle("wrap_rel31");
    rel = 1'b0;
    cycle("wrap_g0");
    check("wrap.idx0", {27'd0, index}, 32'd0);
    rel = 1'b1;
    cycle("wrap_rel0");
    rel = 1'b0;

    // Timeout: single request, no release -> valid for HOLD cycles
    req = 32'h0000_0020;
    cycle("to_grant");
    check("to.idx5", {27'd0, index}, 32'd5);
    req = '0;
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      cycle("to_hold");
      if (!valid) break;
      cnt++;
    end
    check("to.valid_len", cnt, HOLD);
    check("to.pulse", {31'd0, tout}, 32'd1);
    cycle("to_after");
    check("to.pulse_clear", {31'd0, tout}, 32'd0);
    req = '1;
    cycle("to_next");
    check("to.ptr_adv", {27'd0, index}, 32'd6);
    rel = 1'b1;
    cycle("to_rel6");
    rel = 1'b0;

    // Enable drop mid-grant on channel 7 keeps the pointer
    req = 32'h0000_0080;
    cycle("en_g7");
    check("en.idx7", {27'd0, index}, 32'd7);
    en = 1'b0;
    cycle("en_drop");
    check("en.drop_valid", {31'd0, valid}, 32'd0);
    en  = 1'b1;
    req = '1;
    cycle("en_regrant");
    check("en.regrant_idx", {27'd0, index}, 32'd7);
    rel = 1'b1;
    cycle("en_rel7");
    rel = 1'b0;

    // Release coinciding with the timeout cycle is a normal release
    req = 32'h0000_0200;
    cycle("co_grant");
    check("co.idx9", {27'd0, index}, 32'd9);
    req = '0;
    for (int i = 0; i < HOLD - 1; i++) cycle("co_hold");
    rel = 1'b1;
    cycle("co_rel");
    check("co.timeout", {31'd0, tout}, 32'd0);
    check("co.valid", {31'd0, valid}, 32'd0);
    rel = 1'b0;
    req = '1;
    cycle("co_next");
    check("co.ptr_adv", {27'd0, index}, 32'd10);

    // Asynchronous reset between edges while granted
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("areset.valid", {31'd0, valid}, 32'd0);
    check("areset.index", {27'd0, index}, 32'd0);
    check("areset.timeout", {31'd0, tout}, 32'd0);
    cycle("areset_hold");
    rst_n = 1'b1;
    req   = 32'h0000_1008;
    cycle("areset_grant");
    check("areset.from0", {27'd0, index}, 32'd3);
    rel = 1'b1;
    cycle("areset_rel");
    rel = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0: req = '0;
        1: req = 32'h1 << $urandom_range(0, 31);
        2: req = $urandom & $urandom;
        default: req = $urandom;
      endcase
      rel = ($urandom_range(0, 4) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
